// File: rtl/load_return_tracker_pkg.sv
// Shared types for the load return tracker: load op encodings, bus word and tracker entry.
// Optional feature macro used by the tracker: ADEL_CHECK_EN (misaligned-load flagging).
package load_return_tracker_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_LW   = 3'd1,
      OP_LH   = 3'd2,
      OP_LHU  = 3'd3,
      OP_LB   = 3'd4,
      OP_LBU  = 3'd5
   } decoded_op_t;

   // Entries store the destination at this width; the tracker's DST_W must not exceed it.
   localparam int DST_MAX_W = 8;

   typedef struct packed {
      decoded_op_t            op;
      logic [1:0]             addr;
      logic [DST_MAX_W-1:0]   dst;
      word_t                  data;
      logic                   done;
      logic                   killed;
   } load_entry_t;

   function automatic logic is_misaligned(input decoded_op_t op, input logic [1:0] addr);
      logic mis;
      mis = 1'b0;
      case (op)
         OP_LW:         mis = (addr != 2'b00);
         OP_LH, OP_LHU: mis = addr[0];
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_return_tracker_readdata.sv
// Combinational load extractor: selects the addressed byte/half/word of the raw bus word
// and sign- or zero-extends it according to the load op.
module load_return_tracker_readdata
   import load_return_tracker_pkg::*;
(
   input  decoded_op_t op,
   input  logic [1:0]  addr,
   input  word_t       data,
   output word_t       result
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   always_comb begin
      half_sel = addr[1] ? data[31:16] : data[15:0];
      byte_sel = data[7:0];
      case (addr)
         2'd0:    byte_sel = data[7:0];
         2'd1:    byte_sel = data[15:8];
         2'd2:    byte_sel = data[23:16];
         default: byte_sel = data[31:24];
      endcase

      result = '0;
      case (op)
         OP_LW:   result = data;
         OP_LH:   result = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  result = {16'h0000, half_sel};
         OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  result = {24'h000000, byte_sel};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/load_return_tracker.sv
// In-order tracker for outstanding loads: records each load, captures its bus response and
// returns the extended result to writeback. Optional macro ADEL_CHECK_EN adds req_adel.
module load_return_tracker
   import load_return_tracker_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DST_W = 5
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  decoded_op_t      req_op,
   input  logic [1:0]       req_addr,
   input  logic [DST_W-1:0] req_dst,
   input  logic             resp_valid,
   input  word_t            resp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output word_t            out_data,
   output logic [DST_W-1:0] out_dst,
   input  logic             flush,
`ifdef ADEL_CHECK_EN
   output logic             req_adel,
`endif
   output logic             busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   load_entry_t      entry_q [DEPTH];
   load_entry_t      entry_d [DEPTH];
   logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [PTR_W-1:0] resp_ptr_q,  resp_ptr_d;
   logic [PTR_W-1:0] head_ptr_q,  head_ptr_d;
   logic [CNT_W-1:0] count_q,     count_d;
   // Allocated entries still waiting for their bus response.
   logic [CNT_W-1:0] wait_q,      wait_d;

   load_entry_t head_entry;
   word_t       head_result;
   logic        alloc_fire;
   logic        resp_fire;
   logic        pop;
   logic        misaligned;

   load_return_tracker_readdata u_readdata (
      .op     (head_entry.op),
      .addr   (head_entry.addr),
      .data   (head_entry.data),
      .result (head_result)
   );

   always_comb begin
      head_entry = entry_q[head_ptr_q];
      req_ready  = !flush && (count_q < CNT_W'(DEPTH));
`ifdef ADEL_CHECK_EN
      misaligned = is_misaligned(req_op, req_addr);
      req_adel   = req_valid && misaligned;
`else
      misaligned = 1'b0;
`endif
      alloc_fire = req_valid && req_ready && !misaligned;
      resp_fire  = resp_valid && (wait_q != '0);
      out_valid  = (count_q != '0) && head_entry.done && !head_entry.killed;
      // A killed head drains on its own without waiting for writeback.
      pop        = (count_q != '0) && head_entry.done && (head_entry.killed || out_ready);
      out_data   = out_valid ? head_result : '0;
      out_dst    = out_valid ? head_entry.dst[DST_W-1:0] : '0;
      busy       = (count_q != '0);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_d[i] = entry_q[i];
         if (resp_fire && (resp_ptr_q == PTR_W'(i))) begin
            entry_d[i].data = resp_data;
            entry_d[i].done = 1'b1;
         end
         if (flush && (CNT_W'(PTR_W'(PTR_W'(i) - head_ptr_q)) < count_q)) begin
            entry_d[i].killed = 1'b1;
         end
         if (pop && (head_ptr_q == PTR_W'(i))) begin
            entry_d[i].done   = 1'b0;
            entry_d[i].killed = 1'b0;
         end
         if (alloc_fire && (alloc_ptr_q == PTR_W'(i))) begin
            entry_d[i].op     = req_op;
            entry_d[i].addr   = req_addr;
            entry_d[i].dst    = DST_MAX_W'(req_dst);
            entry_d[i].data   = '0;
            entry_d[i].done   = 1'b0;
            entry_d[i].killed = 1'b0;
         end
      end

      alloc_ptr_d = alloc_ptr_q + PTR_W'(alloc_fire);
      resp_ptr_d  = resp_ptr_q + PTR_W'(resp_fire);
      head_ptr_d  = head_ptr_q + PTR_W'(pop);
      count_d     = count_q + CNT_W'(alloc_fire) - CNT_W'(pop);
      wait_d      = wait_q + CNT_W'(alloc_fire) - CNT_W'(resp_fire);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         alloc_ptr_q <= '0;
         resp_ptr_q  <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         wait_q      <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
         end
         alloc_ptr_q <= alloc_ptr_d;
         resp_ptr_q  <= resp_ptr_d;
         head_ptr_q  <= head_ptr_d;
         count_q     <= count_d;
         wait_q      <= wait_d;
      end
   end

endmodule

// File: doc/load_return_tracker.md
Name: load_return_tracker

Overview:
- In-order tracker for outstanding loads between memory-stage issue and writeback.
- Records op, byte offset and destination register per load; captures the bus read response.
- Extracts, sign- or zero-extends the addressed byte/half/word and hands the result to writeback over a valid/ready handshake.
- Read-side counterpart of the store byte-enable/shift logic; supports a flush for exceptions and branch-mispredict kill.

Parameters:
DEPTH, 4, max outstanding loads (power of 2, ≥2)
DST_W, 5, destination register index width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  load issued this cycle
req_ready  out  1  tracker can accept a load
req_op  in  decoded_op_t  LW/LH/LHU/LB/LBU
req_addr  in  2  address bits [1:0]
req_dst  in  DST_W  destination register
resp_valid  in  1  bus data_ok; no backpressure
resp_data  in  32 (word_t)  raw aligned bus word
out_valid  out  1  extracted result available
out_ready  in  1  writeback accepts result
out_data  out  32 (word_t)  extended load result
out_dst  out  DST_W  destination register
flush  in  1  kill all outstanding loads
busy  out  1  count != 0

Behaviour:
- Clock is clk; reset is resetn, synchronous, active-low. On reset: count=0, all pointers 0, all entry flags cleared. Outputs then: req_ready=1, out_valid=0, out_data=0, out_dst=0, busy=0.
- Circular buffer of DEPTH entries. Each entry holds {op, addr, dst, data, done, killed}.
- Three pointers:
  - alloc_ptr: advances on req_valid && req_ready.
  - resp_ptr: advances on an accepted resp_valid.
  - head_ptr: advances on pop.
- Allocation: req_ready = !flush && count < DEPTH. Full blocks allocation even in a cycle that pops; there is no pass-through.
- Response:
  - Accepted when resp_valid and at least one allocated entry has not yet received data.
  - Stores resp_data in the entry at resp_ptr and sets done. Responses are assumed in order.
  - resp_valid with no awaiting entry is ignored; state is unchanged.
- Output:
  - out_valid = head entry done && !killed. out_data/out_dst come combinationally from the head entry.
  - First out_valid occurs in the cycle after the resp_valid that filled the head; response-to-output latency is 1 cycle.
  - Pop on out_valid && out_ready.
  - A done && killed head pops silently, one per cycle, with out_valid=0.
  - out_data=0 when out_valid=0.
- Extraction:
  - LW: data.
  - LH/LHU: half = addr[1] ? data[31:16] : data[15:0]; LH sign-extends bit 15, LHU zero-extends.
  - LB/LBU: byte = data[8*addr+7 : 8*addr]; LB sign-extends bit 7, LBU zero-extends.
  - Any other op: 0.
- Flush:
  - Sets killed on every allocated entry in the same edge, including the head.
  - Killed entries still consume their responses, so the bus stays in step, then drain silently.
  - A request in the flush cycle is not accepted, because req_ready is low.
  - A pop and a flush in the same cycle: the pop completes and the remaining entries are killed.
- Simultaneous alloc + response + pop in one cycle: all three apply. count updates by +1 for alloc and -1 for pop, independently.
- count is a log2(DEPTH)+1 bit register. Pointers wrap modulo DEPTH.
- Reset mid-operation: all entries are discarded. Responses arriving afterwards for pre-reset loads are ignored, because no entry awaits data.

Optional Feature:
ADEL_CHECK_EN
- Defined:
  - Adds output req_adel (1 bit) = req_valid && misaligned. Misaligned means LW with addr != 0, or LH/LHU with addr[0] = 1.
  - A flagged request completes the handshake but allocates no entry; the pipeline raises AdEL.
- Undefined: no check. LW ignores addr; LH/LHU use addr[1] only; a misaligned load is extracted as if aligned down.

Decomposition:
- Shared package: decoded_op_t load encodings (LW, LH, LHU, LB, LBU), word_t, and the entry struct (load_entry_t).
- Sub-module: readdata. A purely combinational extractor (op, addr, raw word -> extended word), mirroring writedata, instantiated on the head entry.

Test Plan:
1. LB addr=2'b11, resp_data=32'h80AA_BBCC -> out_data=32'hFFFF_FF80, out_valid 1 cycle after resp_valid. LBU same -> 32'h0000_0080.
2. LH addr=2'b10, resp_data=32'h7FFF_8000 -> 32'h0000_7FFF. LH addr=2'b00 -> 32'hFFFF_8000. LHU addr=2'b00 -> 32'h0000_8000.
3. Issue 4 loads with no response -> req_ready=0, busy=1. A 5th load is held. Return responses D0..D3 with out_ready=0 then 1 -> outputs D0..D3 in order with correct out_dst; req_ready rises after the first pop.
4. Two loads outstanding, flush, then 2 responses -> no out_valid; busy drops to 0 two cycles after the last response. A new load is then accepted and returns normally.
5. resp_valid with nothing outstanding, and reset asserted with 3 loads pending followed by 3 responses -> no state change, no out_valid.
6. (ADEL_CHECK_EN) LW addr=2'b10 -> req_adel=1, busy stays 0. LH addr=2'b01 -> req_adel=1. LB addr=2'b01 -> req_adel=0 and the load is allocated.
